// File: rtl/rdyval2reqack_arb.sv
// rdyval2reqack_arb
//   Round-robin arbiter that lets NREQ ready/valid producers share one
//   four-phase req/ack output link. Each accepted beat is registered with its
//   source index and forwarded as one complete req/ack transaction. A new beat
//   can be accepted in the same cycle that ack is seen low in WAIT_FALL, so
//   back-to-back transactions need no idle cycle.
//
// Parameters
//   NREQ    number of ready/valid input ports (>= 2)
//   DWIDTH  data width
//   IDW     source-index width, derived as $clog2(NREQ)
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous reset, active high
//   vld    per-port valid
//   rdy    per-port ready (one-hot or zero, forced to zero while rst is high)
//   i_dat  per-port data, port k at [k*DWIDTH +: DWIDTH]
//   req    output request
//   ack    output acknowledge
//   o_dat  registered data of the current transaction
//   o_id   source port index of the current transaction
//   busy   high while a transaction is in flight
//
// Build option
//   RDYVAL2REQACK_ARB_CDC_EN  when defined, ack passes through a two-flop
//                             synchronizer before use; otherwise it is used
//                             directly.

module rdyval2reqack_arb #(
    parameter  int NREQ   = 4,
    parameter  int DWIDTH = 8,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        vld,
    output logic [NREQ-1:0]        rdy,
    input  logic [NREQ*DWIDTH-1:0] i_dat,
    output logic                   req,
    input  logic                   ack,
    output logic [DWIDTH-1:0]      o_dat,
    output logic [IDW-1:0]         o_id,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_FALL
    } state_t;

    state_t            state;
    logic [IDW-1:0]    ptr;
    logic              ack_i;
    logic              accept_en;
    logic              accept;
    logic              win_any;
    logic [IDW-1:0]    win_idx;
    logic [IDW-1:0]    pos;
    logic [DWIDTH-1:0] sel_dat;

    // ------------------------------------------------------------------
    // Acknowledge path
    // ------------------------------------------------------------------
`ifdef RDYVAL2REQACK_ARB_CDC_EN
    logic ack_meta;
    logic ack_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            ack_meta <= ack;
            ack_sync <= ack_meta;
        end
    end

    assign ack_i = ack_sync;
`else
    assign ack_i = ack;
`endif

    // ------------------------------------------------------------------
    // Round-robin grant
    // ------------------------------------------------------------------
    // Index that is `step` positions after `base`, wrapping modulo NREQ so
    // unused index codes are skipped when NREQ is not a power of two.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] base,
                                                input int unsigned    step);
        int unsigned sum;
        sum = (32'(base) + step) % NREQ;
        return IDW'(sum);
    endfunction

    // Search starts just after the last winner, which therefore ends up
    // with the lowest priority.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        pos     = '0;
        for (int unsigned step = 1; step <= NREQ; step++) begin
            pos = next_idx(ptr, step);
            if (!win_any && vld[pos]) begin
                win_any = 1'b1;
                win_idx = pos;
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (win_idx == IDW'(k)) begin
                sel_dat = i_dat[k*DWIDTH +: DWIDTH];
            end
        end
    end

    // A beat may be taken when idle, or while the previous handshake is
    // finishing and ack has already been seen low.
    assign accept_en = (state == IDLE) || ((state == WAIT_FALL) && !ack_i);
    assign rdy       = (win_any && accept_en && !rst) ? (NREQ'(1) << win_idx) : '0;
    assign accept    = |(rdy & vld);
    assign busy      = (state != IDLE);

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            req   <= 1'b0;
            o_dat <= '0;
            o_id  <= '0;
            ptr   <= IDW'(NREQ - 1);
        end else if (accept) begin
            o_dat <= sel_dat;
            o_id  <= win_idx;
            ptr   <= win_idx;
            req   <= 1'b1;
            state <= REQ;
        end else begin
            case (state)
                REQ: begin
                    if (ack_i) begin
                        req   <= 1'b0;
                        state <= WAIT_FALL;
                    end
                end
                WAIT_FALL: begin
                    if (!ack_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Flags an acknowledge that arrives while idle without being the tail
    // of a just-finished handshake.
    state_t prev_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state <= IDLE;
        end else begin
            prev_state <= state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            spurious_ack_idle: assert (!(ack_i && (state == IDLE) && (prev_state != WAIT_FALL)))
                else $warning("rdyval2reqack_arb: spurious ack while idle");
        end
    end
`endif

endmodule

// File: tb/tb_rdyval2reqack_arb.sv
module tb_rdyval2reqack_arb;

    localparam int NREQ = 4;
    localparam int DW   = 8;
`ifdef RDYVAL2REQACK_ARB_CDC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  vld;
    logic [NREQ-1:0]  rdy;
    logic [NREQ*DW-1:0] i_dat;
    logic             req;
    logic             ack;
    logic [DW-1:0]    o_dat;
    logic [1:0]       o_id;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rdyval2reqack_arb #(
        .NREQ   (NREQ),
        .DWIDTH (DW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .vld   (vld),
        .rdy   (rdy),
        .i_dat (i_dat),
        .req   (req),
        .ack   (ack),
        .o_dat (o_dat),
        .o_id  (o_id),
        .busy  (busy)
    );

    // ------------------------------------------------------------------
    // Reference model: a handshake is either outstanding (request raised),
    // finishing (request dropped, waiting for ack to go away) or absent.
    // The next winner is the first valid port after the last winner.
    // ------------------------------------------------------------------
    logic            m_req;
    logic            m_wf;
    logic [DW-1:0]   m_dat;
    logic [1:0]      m_id;
    int              m_ptr;
    logic [1:0]      m_ah;
    logic            m_acki;
    logic            m_en;
    int              m_win;
    logic [NREQ-1:0] m_rdy;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int s = 1; s <= NREQ; s++) begin
            int j;
            j = (p + s) % NREQ;
            if (v[j[1:0]]) return j;
        end
        return -1;
    endfunction

    always_comb begin
        m_acki = (S == 0) ? ack : m_ah[1];
        m_en   = !rst && !m_req && !(m_wf && m_acki);
        m_win  = rr_pick(vld, m_ptr);
        m_rdy  = '0;
        if (m_en && m_win >= 0) m_rdy[m_win[1:0]] = 1'b1;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_req <= 1'b0;
            m_wf  <= 1'b0;
            m_dat <= '0;
            m_id  <= '0;
            m_ptr <= NREQ - 1;
            m_ah  <= '0;
        end else begin
            m_ah <= {m_ah[0], ack};
            if (|(m_rdy & vld)) begin
                m_req <= 1'b1;
                m_wf  <= 1'b0;
                m_dat <= i_dat[m_win*DW +: DW];
                m_id  <= m_win[1:0];
                m_ptr <= m_win;
            end else if (m_req && m_acki) begin
                m_req <= 1'b0;
                m_wf  <= 1'b1;
            end else if (m_wf && !m_acki) begin
                m_wf <= 1'b0;
            end
        end
    end

    // Advance one clock; inputs are changed and outputs sampled between edges.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Complete any outstanding handshake and return to idle.
    task automatic drain();
        vld = '0;
        for (int c = 0; c < 40; c++) begin
            ack = req;
            cyc();
            if (!busy && !ack) break;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vld = '1; ack = 1'b0; i_dat = 32'h11223344;
        cyc(); cyc(); #1;
        checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy: got %b expected 0000", rdy); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (o_dat !== 8'h00) begin errors++; $display("FAIL reset_o_dat: got %h expected 00", o_dat); end
        checks++; if (o_id !== 2'd0) begin errors++; $display("FAIL reset_o_id: got %0d expected 0", o_id); end
        rst = 1'b0; vld = '0;
        cyc();
    endtask

    task automatic test_single_port();
        vld = 4'b0100; ack = 1'b0;
        i_dat = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
        #1;
        checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL sp_rdy: got %b expected 0100", rdy); end
        cyc(); vld = '0; #1;
        checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL sp_rdy_pulse: got %b expected 0000", rdy); end
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL sp_req_rise: got %b expected 1", req); end
        checks++; if (o_dat !== 8'hA5) begin errors++; $display("FAIL sp_o_dat: got %h expected a5", o_dat); end
        checks++; if (o_id !== 2'd2) begin errors++; $display("FAIL sp_o_id: got %0d expected 2", o_id); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sp_busy: got %b expected 1", busy); end
        cyc(); cyc(); cyc();
        ack = 1'b1;
        for (int i = 0; i <= S; i++) begin
            logic exp_req;
            cyc(); #1;
            exp_req = (i == S) ? 1'b0 : 1'b1;
            checks++; if (req !== exp_req) begin errors++; $display("FAIL sp_req_fall[%0d]: got %b expected %b", i, req, exp_req); end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sp_busy_wait: got %b expected 1", busy); end
        checks++; if (o_dat !== 8'hA5) begin errors++; $display("FAIL sp_o_dat_hold: got %h expected a5", o_dat); end
        ack = 1'b0;
        for (int i = 0; i <= S; i++) begin
            logic exp_busy;
            cyc(); #1;
            exp_busy = (i == S) ? 1'b0 : 1'b1;
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL sp_busy_clear[%0d]: got %b expected %b", i, busy, exp_busy); end
        end
    endtask

    task automatic test_round_robin();
        int got[$];
        logic prev;
        rst = 1'b1; vld = '0; ack = 1'b0;
        cyc();
        rst = 1'b0; vld = '1; i_dat = 32'hDEADBEEF;
        prev = 1'b0;
        for (int c = 0; c < 200 && got.size() < 6; c++) begin
            cyc();
            if (req && !prev) got.push_back(int'(o_id));
            prev = req;
            ack = req;
        end
        checks++;
        if (got.size() != 6) begin
            errors++; $display("FAIL rr_timeout: got %0d grants expected 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got[i] != i % NREQ) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got[i], i % NREQ); end
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        vld = 4'b0010; ack = 1'b0; i_dat = 32'h0000_7700;
        #1;
        checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL b2b_first_rdy: got %b expected 0010", rdy); end
        cyc();
        ack = 1'b1;
        for (int c = 0; c < 20 && req; c++) cyc();
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL b2b_req_fall_timeout: got %b expected 0", req); end
        cyc(); #1;
        checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL b2b_hold_rdy: got %b expected 0000", rdy); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_hold_busy: got %b expected 1", busy); end
        ack = 1'b0;
        for (int i = 0; i < S; i++) begin
            #1;
            checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL b2b_sync_rdy[%0d]: got %b expected 0000", i, rdy); end
            cyc();
        end
        #1;
        checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL b2b_rdy_on_fall: got %b expected 0010", rdy); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle: got %b expected 1", busy); end
        cyc(); #1;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL b2b_req_next: got %b expected 1", req); end
        checks++; if (o_id !== 2'd1) begin errors++; $display("FAIL b2b_o_id: got %0d expected 1", o_id); end
        checks++; if (o_dat !== 8'h77) begin errors++; $display("FAIL b2b_o_dat: got %h expected 77", o_dat); end
        drain();
    endtask

    task automatic test_reset_mid();
        vld = 4'b1000; ack = 1'b0; i_dat = 32'h9900_0000;
        cyc(); #1;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL rm_req_before: got %b expected 1", req); end
        rst = 1'b1; vld = '1; #1;
        checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL rm_rdy_in_reset: got %b expected 0000", rdy); end
        cyc();
        rst = 1'b0; #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b expected 0", req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
        checks++; if (o_id !== 2'd0) begin errors++; $display("FAIL rm_o_id: got %0d expected 0", o_id); end
        checks++; if (o_dat !== 8'h00) begin errors++; $display("FAIL rm_o_dat: got %h expected 00", o_dat); end
        checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL rm_grant0: got %b expected 0001", rdy); end
        cyc(); #1;
        checks++; if (o_id !== 2'd0) begin errors++; $display("FAIL rm_o_id_next: got %0d expected 0", o_id); end
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL rm_req_next: got %b expected 1", req); end
        drain();
    endtask

    task automatic test_spurious_ack();
        vld = '0; ack = 1'b1;
        for (int c = 0; c < 3 + S; c++) begin
            cyc(); #1;
            checks++; if (req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL spur_idle[%0d]: req=%b busy=%b expected 0 0", c, req, busy); end
        end
        ack = 1'b0;
        repeat (S + 1) cyc();
        vld = 4'b1000; i_dat = 32'h4400_0000; #1;
        checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL spur_rdy: got %b expected 1000", rdy); end
        cyc();
        ack = 1'b1;
        for (int c = 0; c < 20 && req; c++) cyc();
        for (int c = 0; c < 3; c++) begin
            cyc(); #1;
            checks++; if (rdy !== 4'b0000 || req !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL spur_hold[%0d]: rdy=%b req=%b busy=%b expected 0000 0 1", c, rdy, req, busy);
            end
        end
        ack = 1'b0;
        repeat (S) cyc();
        #1;
        checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL spur_release: got %b expected 1000", rdy); end
        drain();
    endtask

    task automatic test_random();
        rst = 1'b1; vld = '0; ack = 1'b0;
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            vld   = NREQ'($urandom);
            i_dat = $urandom;
            if (rst) ack = 1'b0;
            else if (req && $urandom_range(0, 2) == 0) ack = 1'b1;
            else if (!req && $urandom_range(0, 1) == 0) ack = 1'b0;
            #1;
            checks++; if (rdy !== m_rdy) begin errors++; $display("FAIL rnd_rdy[%0d]: got %b expected %b", c, rdy, m_rdy); end
            checks++; if (req !== m_req) begin errors++; $display("FAIL rnd_req[%0d]: got %b expected %b", c, req, m_req); end
            checks++; if (busy !== (m_req | m_wf)) begin errors++; $display("FAIL rnd_busy[%0d]: got %b expected %b", c, busy, m_req | m_wf); end
            checks++; if (o_dat !== m_dat) begin errors++; $display("FAIL rnd_o_dat[%0d]: got %h expected %h", c, o_dat, m_dat); end
            checks++; if (o_id !== m_id) begin errors++; $display("FAIL rnd_o_id[%0d]: got %0d expected %0d", c, o_id, m_id); end
            cyc();
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; vld = '0; ack = 1'b0; i_dat = '0;
        test_reset();
        test_single_port();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        test_spurious_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rdyval2reqack_arb.md
Name: rdyval2reqack_arb

Overview:
- Round-robin arbiter that shares one four-phase Request–Acknowledge output channel among NREQ Ready–Valid input ports.
- Each accepted input beat is registered with its source index and forwarded as one complete req/ack transaction.
- Sits in front of a clock-domain or slow-peripheral boundary where several producers must share a single handshake link.

Parameters:
NREQ, 4, number of Ready–Valid input ports (>=2)
DWIDTH, 8, data path bit width
IDW, $clog2(NREQ), width of source-index field (derived, not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active high
vld  input  NREQ  per-port Valid
rdy  output  NREQ  per-port Ready
i_dat  input  NREQ*DWIDTH  per-port data; port k occupies bits [k*DWIDTH +: DWIDTH]
req  output  1  output Request
ack  input  1  output Acknowledge
o_dat  output  DWIDTH  registered data of the current transaction
o_id  output  IDW  source port index of the current transaction
busy  output  1  high while a transaction is in flight (state != IDLE)

Interface decision: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, req=0, o_dat=0, o_id=0, ptr=NREQ-1. While rst=1, rdy is forced to all-zero.
- ack_i: internal acknowledge; equals ack, or its synchronized version (see Optional Feature).
- FSM states:
  - IDLE: req=0.
  - REQ: req=1, waiting for ack_i=1.
  - WAIT_FALL: req=0, waiting for ack_i=0.
- accept_en = (state==IDLE) | (state==WAIT_FALL & ~ack_i).
- Grant (combinational, one-hot or zero):
  - Search vld from index ptr+1 upward, wrapping modulo NREQ; the first set bit wins.
  - rdy = grant & {NREQ{accept_en}}.
  - rdy may depend on vld; vld must not depend on rdy.
- Accept: if any rdy[k]&vld[k] at a posedge:
  - o_dat <= port k data, o_id <= k, ptr <= k;
  - req <= 1, state <= REQ.
  - This holds from both IDLE and WAIT_FALL (zero-bubble back-to-back).
- REQ: on ack_i=1 → req <= 0, state <= WAIT_FALL. o_dat and o_id stay stable from req rise until the next accept.
- WAIT_FALL:
  - ack_i=0 with no accept → state <= IDLE.
  - ack_i=0 with accept → state <= REQ directly.
  - ack_i=1 → hold.
- Latency:
  - Accept cycle N → req=1 at N+1.
  - ack_i high sampled at cycle M → req=0 at M+1.
  - ack_i low in WAIT_FALL gives rdy in the same cycle.
- Fairness: the granted port becomes lowest priority. With all ports continuously valid, the grant order is 0,1,…,NREQ-1,0,…
- At most one input beat is accepted per transaction. No beat is accepted while state==REQ.
- Spurious ack in IDLE: ignored, no state change. A non-synthesis assertion flags ack_i=1 in IDLE when the previous state was not WAIT_FALL.
- Reset mid-transaction: req drops on the next cycle, any captured beat is discarded, and ptr restarts at NREQ-1.
- NREQ not a power of two: wrap-around skips the unused indices; o_id never exceeds NREQ-1.

Optional Feature:
- Macro: RDYVAL2REQACK_ARB_CDC_EN
- Defined: ack passes through a 2-flop synchronizer (synchronous reset to 0) and ack_i = sync output. All ack-related transitions shift by 2 cycles.
- Undefined: ack_i = ack directly, with no added flops.

Test Plan:
- Single port: vld[2]=1, dat=0xA5, ack returns 3 cycles after req → rdy[2] pulses 1 cycle; req=1 next cycle with o_dat=0xA5, o_id=2; req falls 1 cycle after ack; busy clears when ack falls.
- All four vld held high, ack responder with 1-cycle delay → accepted o_id sequence 0,1,2,3,0,1; no port is granted twice before every other valid port is served.
- Back-to-back: vld[1] held, ack falls at cycle T in WAIT_FALL → rdy[1]=1 at T; req=1 at T+1 (no IDLE cycle).
- Reset mid-REQ: rst=1 for 1 cycle while req=1 → req=0, busy=0, o_id=0 after reset; the next arbitration with vld=4'b1111 grants port 0.
- Spurious ack=1 in IDLE with vld=0 → no req, state stays IDLE, assertion fires. With vld[3]=1 and ack held high from REQ through WAIT_FALL → no new accept until ack=0.
- RDYVAL2REQACK_ARB_CDC_EN defined: repeat the single-port test → req falls 3 cycles after ack rises (2 sync + 1); rdy returns 2 cycles after ack falls.
